// File: rtl/oserdes_ctrl_pkg.sv
// Shared types and constants for the O_SERDES TX bring-up controller.
// Trim constants only matter when OSERDES_CTRL_TAP_TRIM_EN is defined.
package oserdes_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    DLOAD,
    TRIM,
    RUN
  } state_t;

  localparam int TAP_W          = 6;
  localparam int SETTLE_CYCLES  = 3;
  localparam int MAX_TRIM_STEPS = 64;

  // Bits needed to count from 0 up to n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/oserdes_ctrl_fifo2.sv
// Two-entry word buffer between the fabric stream and the serializer.
// Flush empties it in one cycle; push when full and pop when empty are ignored.
module oserdes_ctrl_fifo2
  import oserdes_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/oserdes_tx_ctrl.sv
// Bring-up sequencer and word feeder for one O_SERDES TX channel.
// Define OSERDES_CTRL_TAP_TRIM_EN to add the TAP_TARGET port and TRIM state.
module oserdes_tx_ctrl
  import oserdes_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               LOCK_STABLE = 16,
  parameter int               RST_CYCLES  = 8,
  parameter int               LOAD_DIV    = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PLL_LOCK,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] SERDES_D,
  output logic             SERDES_RST,
  output logic             LOAD_WORD,
  output logic             OE,
  output logic             CLK_EN,
  output logic             DLY_LOAD,
  output logic             DLY_ADJ,
  output logic             DLY_INCDEC,
  input  logic [5:0]       DLY_TAP_VALUE,
`ifdef OSERDES_CTRL_TAP_TRIM_EN
  input  logic [5:0]       TAP_TARGET,
`endif
  output logic             LINK_UP,
  output logic             UNDERRUN
);

  localparam int LCW = cnt_w(LOCK_STABLE);
  localparam int HCW = cnt_w(RST_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_STABLE - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_CYCLES - 1);
  localparam logic [3:0]     DIV_LAST  = 4'(LOAD_DIV - 1);

  state_t           state;
  state_t           next;
  logic             lock_meta;
  logic             lock_sync;
  logic             lock_lost;
  logic [LCW-1:0]   lock_cnt;
  logic [HCW-1:0]   hold_cnt;
  logic [3:0]       div_cnt;
  logic             strobe;
  logic             f_push;
  logic             f_pop;
  logic             f_full;
  logic             f_empty;
  logic [WIDTH-1:0] f_dout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_sync <= lock_meta;
    end
  end

  // Lock loss overrides every state except WAIT_LOCK itself.
  assign lock_lost = (state != WAIT_LOCK) & ~lock_sync;

`ifdef OSERDES_CTRL_TAP_TRIM_EN
  logic [1:0] settle;
  logic [6:0] steps;
  logic       trim_done;
  logic       adj_fire;

  assign trim_done = (settle == 2'd0) &
                     ((DLY_TAP_VALUE == TAP_TARGET) |
                      (steps == 7'(MAX_TRIM_STEPS)));
  assign adj_fire   = (state == TRIM) & lock_sync &
                      (settle == 2'd0) & ~trim_done;
  assign DLY_ADJ    = adj_fire;
  assign DLY_INCDEC = adj_fire & (TAP_TARGET > DLY_TAP_VALUE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      settle <= 2'd0;
      steps  <= 7'd0;
    end else if (state != TRIM || lock_lost) begin
      settle <= 2'd0;
      steps  <= 7'd0;
    end else if (adj_fire) begin
      settle <= 2'(SETTLE_CYCLES);
      steps  <= steps + 7'd1;
    end else if (settle != 2'd0) begin
      settle <= settle - 2'd1;
    end
  end
`else
  logic unused_tap;

  assign unused_tap = ^DLY_TAP_VALUE;
  assign DLY_ADJ    = 1'b0;
  assign DLY_INCDEC = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      lock_cnt <= (state == WAIT_LOCK && lock_sync) ?
                  lock_cnt + 1'b1 : '0;
      hold_cnt <= (state == HOLD && !lock_lost) ?
                  hold_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= WAIT_LOCK;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    SERDES_RST = 1'b1;
    CLK_EN     = 1'b0;
    OE         = 1'b0;
    LINK_UP    = 1'b0;
    DLY_LOAD   = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_sync && lock_cnt == LOCK_LAST) next = HOLD;
      end
      HOLD: begin
        CLK_EN = 1'b1;
        if (hold_cnt == HOLD_LAST) next = DLOAD;
      end
      DLOAD: begin
        SERDES_RST = 1'b0;
        CLK_EN     = 1'b1;
        DLY_LOAD   = 1'b1;
`ifdef OSERDES_CTRL_TAP_TRIM_EN
        next = TRIM;
`else
        next = RUN;
`endif
      end
      TRIM: begin
        SERDES_RST = 1'b0;
        CLK_EN     = 1'b1;
`ifdef OSERDES_CTRL_TAP_TRIM_EN
        if (trim_done) next = RUN;
`else
        next = RUN;
`endif
      end
      RUN: begin
        SERDES_RST = 1'b0;
        CLK_EN     = 1'b1;
        OE         = 1'b1;
        LINK_UP    = 1'b1;
      end
      default: next = WAIT_LOCK;
    endcase
    if (lock_lost) next = WAIT_LOCK;
  end

  assign S_READY = (state == RUN) & ~f_full;
  assign strobe  = (state == RUN) & lock_sync & (div_cnt == DIV_LAST);
  assign f_push  = S_VALID & S_READY;
  assign f_pop   = strobe & ~f_empty;

  oserdes_ctrl_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .flush(lock_lost),
    .push (f_push),
    .pop  (f_pop),
    .din  (S_DATA),
    .dout (f_dout),
    .full (f_full),
    .empty(f_empty)
  );

  // Word and strobe are registered together so they reach the serializer aligned.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt   <= 4'd0;
      SERDES_D  <= IDLE_WORD;
      LOAD_WORD <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else if (state != RUN || lock_lost) begin
      div_cnt   <= 4'd0;
      SERDES_D  <= IDLE_WORD;
      LOAD_WORD <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else if (strobe) begin
      div_cnt   <= 4'd0;
      SERDES_D  <= f_empty ? IDLE_WORD : f_dout;
      LOAD_WORD <= 1'b1;
      UNDERRUN  <= f_empty;
    end else begin
      div_cnt   <= div_cnt + 4'd1;
      LOAD_WORD <= 1'b0;
      UNDERRUN  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oserdes_tx_ctrl.sv
// Directed bench for oserdes_tx_ctrl: one LOAD_DIV=1 and one LOAD_DIV=4 instance.
// Trim scenarios run only when OSERDES_CTRL_TAP_TRIM_EN is defined.
module tb_oserdes_tx_ctrl;

  localparam logic [3:0] IDLE = 4'hA;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;

  logic [3:0] s_data1, d1_d;
  logic       s_valid1, s_ready1, d1_srst, d1_load, d1_oe, d1_clken;
  logic       d1_dload, d1_adj, d1_incdec, d1_link, d1_under;
  logic [5:0] tap1, tap_static1;

  logic [3:0] s_data4, d4_d;
  logic       s_valid4, s_ready4, d4_srst, d4_load, d4_oe, d4_clken;
  logic       d4_dload, d4_adj, d4_incdec, d4_link, d4_under;
  logic [5:0] tap4;

`ifdef OSERDES_CTRL_TAP_TRIM_EN
  logic [5:0] tgt1, tgt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oserdes_tx_ctrl #(
    .WIDTH(4), .LOCK_STABLE(16), .RST_CYCLES(8),
    .LOAD_DIV(1), .IDLE_WORD(IDLE)
  ) u_dut1 (
    .CLK(clk), .RST(rst), .PLL_LOCK(pll_lock),
    .S_DATA(s_data1), .S_VALID(s_valid1), .S_READY(s_ready1),
    .SERDES_D(d1_d), .SERDES_RST(d1_srst), .LOAD_WORD(d1_load),
    .OE(d1_oe), .CLK_EN(d1_clken), .DLY_LOAD(d1_dload),
    .DLY_ADJ(d1_adj), .DLY_INCDEC(d1_incdec),
    .DLY_TAP_VALUE(tap1),
`ifdef OSERDES_CTRL_TAP_TRIM_EN
    .TAP_TARGET(tgt1),
`endif
    .LINK_UP(d1_link), .UNDERRUN(d1_under)
  );

  oserdes_tx_ctrl #(
    .WIDTH(4), .LOCK_STABLE(16), .RST_CYCLES(8),
    .LOAD_DIV(4), .IDLE_WORD(IDLE)
  ) u_dut4 (
    .CLK(clk), .RST(rst), .PLL_LOCK(pll_lock),
    .S_DATA(s_data4), .S_VALID(s_valid4), .S_READY(s_ready4),
    .SERDES_D(d4_d), .SERDES_RST(d4_srst), .LOAD_WORD(d4_load),
    .OE(d4_oe), .CLK_EN(d4_clken), .DLY_LOAD(d4_dload),
    .DLY_ADJ(d4_adj), .DLY_INCDEC(d4_incdec),
    .DLY_TAP_VALUE(tap4),
`ifdef OSERDES_CTRL_TAP_TRIM_EN
    .TAP_TARGET(tgt4),
`endif
    .LINK_UP(d4_link), .UNDERRUN(d4_under)
  );

  // Delay-line model: DLY_LOAD restores the static tap, DLY_ADJ steps it.
  always @(posedge clk) begin
    if (rst) begin
      tap1 <= 6'd0;
      tap4 <= 6'd0;
    end else begin
      if (d1_dload) tap1 <= tap_static1;
      else if (d1_adj) tap1 <= d1_incdec ? tap1 + 6'd1 : tap1 - 6'd1;
      if (d4_dload) tap4 <= 6'd0;
      else if (d4_adj) tap4 <= d4_incdec ? tap4 + 6'd1 : tap4 - 6'd1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pll_lock = 1'b0;
    s_valid1 = 1'b0; s_data1 = 4'd0;
    s_valid4 = 1'b0; s_data4 = 4'd0;
    tap_static1 = 6'd0;
`ifdef OSERDES_CTRL_TAP_TRIM_EN
    tgt1 = 6'd0; tgt4 = 6'd0;
`endif
    step; step;
    checks++;
    if ({d1_srst, d1_oe, d1_clken, d1_dload, d1_link, d1_under,
         d1_load, s_ready1, d1_adj, d1_incdec} !== 10'b1000000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b",
        {d1_srst, d1_oe, d1_clken, d1_dload, d1_link, d1_under,
         d1_load, s_ready1, d1_adj, d1_incdec}, 10'b1000000000);
    end
    checks++;
    if (d1_d !== IDLE) begin
      errors++;
      $display("FAIL reset_data: got %h want %h", d1_d, IDLE);
    end
    rst = 1'b0;
    step;
  endtask

  int loads1, adjs1;

  task automatic test_lock_glitch;
    int n, clken_at, rst_fall, early;
    early = 0;
    pll_lock = 1'b1;
    repeat (10) begin step; if (d1_clken) early++; end
    pll_lock = 1'b0;
    step; if (d1_clken) early++;
    pll_lock = 1'b1;
    n = 0; clken_at = -1; rst_fall = -1; loads1 = 0; adjs1 = 0;
    while (n < 60 && rst_fall < 0) begin
      step; n++;
      if (d1_clken && clken_at < 0) clken_at = n;
      if (!d1_srst) rst_fall = n;
      if (d1_dload) loads1++;
      if (d1_adj) adjs1++;
      if (early == 0 && d1_clken && n < 18) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL glitch_early_hold: got %0d early CLK_EN cycles want 0", early);
    end
    checks++;
    if (clken_at !== 18) begin
      errors++;
      $display("FAIL glitch_hold_entry: got cycle %0d want 18", clken_at);
    end
    checks++;
    if (rst_fall !== 26) begin
      errors++;
      $display("FAIL glitch_rst_release: got cycle %0d want 26", rst_fall);
    end
  endtask

  task automatic test_bring_up;
    checks++;
    if (d1_dload !== 1'b1) begin
      errors++;
      $display("FAIL bring_dly_load: got %b want 1", d1_dload);
    end
    step;
    if (d1_dload) loads1++;
`ifdef OSERDES_CTRL_TAP_TRIM_EN
    checks++;
    if (d1_link !== 1'b0) begin
      errors++;
      $display("FAIL bring_trim_link: got %b want 0", d1_link);
    end
    step;
    if (d1_dload) loads1++;
`endif
    checks++;
    if ({d1_link, d1_oe, s_ready1, d1_srst} !== 4'b1110) begin
      errors++;
      $display("FAIL bring_run: got %b want 1110",
        {d1_link, d1_oe, s_ready1, d1_srst});
    end
    repeat (4) begin
      step;
      if (d1_dload) loads1++;
      if (d1_adj) adjs1++;
    end
    checks++;
    if (loads1 !== 1) begin
      errors++;
      $display("FAIL bring_load_count: got %0d want 1", loads1);
    end
    checks++;
    if (adjs1 !== 0) begin
      errors++;
      $display("FAIL bring_adj_count: got %0d want 0", adjs1);
    end
  endtask

  task automatic test_streaming;
    logic [3:0] exp_d [5];
    logic       exp_u [5];
    exp_d = '{IDLE, 4'h1, 4'h2, 4'h3, IDLE};
    exp_u = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        s_data1 = 4'(i + 1);
        s_valid1 = 1'b1;
      end else begin
        s_valid1 = 1'b0;
      end
      step;
      checks++;
      if ({d1_load, d1_under, d1_d} !== {1'b1, exp_u[i], exp_d[i]}) begin
        errors++;
        $display("FAIL stream_%0d: got load=%b under=%b d=%h want load=1 under=%b d=%h",
          i, d1_load, d1_under, d1_d, exp_u[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int n, nacc, q;
    logic acc, exp_rdy, exp_ld;
    logic [3:0] exp_d;
    n = 0;
    while (n < 8 && !d4_load) begin step; n++; end
    checks++;
    if ({d4_load, s_ready4} !== 2'b11) begin
      errors++;
      $display("FAIL bp_sync: got load=%b ready=%b want 1 1", d4_load, s_ready4);
    end
    s_data4 = 4'd1; s_valid4 = 1'b1; nacc = 0;
    for (int k = 1; k <= 16; k++) begin
      acc = s_ready4;
      step;
      if (acc) begin nacc++; s_data4 = s_data4 + 4'd1; end
      q = k / 4;
      exp_rdy = (k == 1) || (k % 4 == 0);
      exp_ld = (k % 4 == 0);
      exp_d = (q == 0) ? IDLE : 4'(q);
      checks++;
      if ({s_ready4, d4_load, d4_d} !== {exp_rdy, exp_ld, exp_d}) begin
        errors++;
        $display("FAIL bp_k%0d: got ready=%b load=%b d=%h want ready=%b load=%b d=%h",
          k, s_ready4, d4_load, d4_d, exp_rdy, exp_ld, exp_d);
      end
    end
    checks++;
    if (nacc !== 5) begin
      errors++;
      $display("FAIL bp_accepts: got %0d want 5", nacc);
    end
  endtask

  task automatic test_lock_loss;
    int n, lds;
    step;
    s_valid4 = 1'b0;
    checks++;
    if (s_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL loss_full: got ready=%b want 0", s_ready4);
    end
    pll_lock = 1'b0;
    step;
    checks++;
    if (d4_link !== 1'b1) begin
      errors++;
      $display("FAIL loss_c1: got link=%b want 1", d4_link);
    end
    step;
    checks++;
    if (d4_link !== 1'b1) begin
      errors++;
      $display("FAIL loss_c2: got link=%b want 1", d4_link);
    end
    step;
    checks++;
    if ({d4_link, d4_srst, d4_oe, s_ready4, d4_load, d4_clken, d4_d}
        !== {6'b010000, IDLE}) begin
      errors++;
      $display("FAIL loss_c3: got %b d=%h want 010000 d=%h",
        {d4_link, d4_srst, d4_oe, s_ready4, d4_load, d4_clken}, d4_d, IDLE);
    end
    pll_lock = 1'b1;
    n = 0;
    while (n < 80 && !d4_link) begin step; n++; end
    checks++;
    if (d4_link !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock: got link=%b want 1", d4_link);
    end
    lds = 0;
    repeat (12) begin
      step;
      if (d4_load) begin
        lds++;
        checks++;
        if ({d4_under, d4_d} !== {1'b1, IDLE}) begin
          errors++;
          $display("FAIL loss_stale: got under=%b d=%h want 1 %h",
            d4_under, d4_d, IDLE);
        end
      end
    end
    checks++;
    if (lds !== 3) begin
      errors++;
      $display("FAIL loss_strobes: got %0d want 3", lds);
    end
  endtask

`ifdef OSERDES_CTRL_TAP_TRIM_EN
  task automatic test_tap_trim;
    logic [5:0] stat [2];
    logic [5:0] tgt [2];
    int         expn [2];
    logic       dir [2];
    int n, pulses, last, sp_err, dir_err;
    stat = '{6'd0, 6'd10};
    tgt  = '{6'd5, 6'd7};
    expn = '{5, 3};
    dir  = '{1'b1, 1'b0};
    for (int p = 0; p < 2; p++) begin
      pll_lock = 1'b0;
      repeat (4) step;
      tap_static1 = stat[p];
      tgt1 = tgt[p];
      pll_lock = 1'b1;
      n = 0; pulses = 0; last = -1; sp_err = 0; dir_err = 0;
      while (n < 300 && !d1_link) begin
        step; n++;
        if (d1_adj) begin
          pulses++;
          if (last >= 0 && n - last != 4) sp_err++;
          last = n;
          if (d1_incdec !== dir[p]) dir_err++;
        end
      end
      checks++;
      if ({d1_link, tap1} !== {1'b1, tgt[p]}) begin
        errors++;
        $display("FAIL trim%0d_end: got link=%b tap=%0d want 1 %0d",
          p, d1_link, tap1, tgt[p]);
      end
      checks++;
      if (pulses !== expn[p]) begin
        errors++;
        $display("FAIL trim%0d_pulses: got %0d want %0d", p, pulses, expn[p]);
      end
      checks++;
      if ({sp_err, dir_err} !== 64'd0) begin
        errors++;
        $display("FAIL trim%0d_shape: got %0d spacing and %0d dir errors want 0",
          p, sp_err, dir_err);
      end
    end
  endtask
`endif

  task automatic test_async_reset;
    checks++;
    if (d1_link !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got link=%b want 1", d1_link);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({d1_srst, d1_link, d1_clken, d1_oe, d1_d} !== {4'b1000, IDLE}) begin
      errors++;
      $display("FAIL arst_now: got %b d=%h want 1000 d=%h",
        {d1_srst, d1_link, d1_clken, d1_oe}, d1_d, IDLE);
    end
    step;
    rst = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_lock_glitch;
    test_bring_up;
    test_streaming;
    test_backpressure;
    test_lock_loss;
`ifdef OSERDES_CTRL_TAP_TRIM_EN
    test_tap_trim;
`endif
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
